// File: rtl/spi_slave_resp.sv
// spi_slave_resp: SPI mode-0 responder for the ADC-board link.
// Receives a FRAME_BITS command frame on mosi while cs_n is low. Returns a
// TX_BITS word on miso, MSB first. sclk, cs_n and mosi are oversampled by
// clk through two-flop synchronisers plus a third flop used for edge detect.
// Optional build macro: SPI_SLAVE_RESP_MISO_TRISTATE_EN. When it is defined,
// miso floats (1'bz) whenever the block is not in an active frame.
module spi_slave_resp #(
    parameter int FRAME_BITS = 32,
    parameter int TX_BITS    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    input  logic [TX_BITS-1:0]    tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready
);

    localparam int CNT_W = $clog2(FRAME_BITS + 2);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        ABORT
    } state_t;

    state_t state_q, state_d;

    logic [2:0]            sclk_sync, cs_sync, mosi_sync;
    logic [1:0]            sync_primed;
    logic                  armed;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] rx_shift;
    logic [TX_BITS-1:0]    tx_shift;
    logic [TX_BITS-1:0]    tx_hold;
    logic                  tx_pending;
    logic                  close_ok_q, close_err_q;
    logic                  miso_q;
    logic                  start, close_ok, close_err;

    // Synchronised edges. Stage [1] is the second sync flop, and stage [2] is the edge-detect flop.
    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign mosi_s    = mosi_sync[2];

    assign tx_ready = ~tx_pending;

    // Pin synchronisers. sync_primed marks when stage [1] holds a real pin sample rather than its reset value.
    // NOTE: sequential state is written with non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync   <= 3'b000;
            cs_sync     <= 3'b111;
            mosi_sync   <= 3'b000;
            sync_primed <= 2'b00;
        end else begin
            sclk_sync   <= {sclk_sync[1:0], sclk};
            cs_sync     <= {cs_sync[1:0], cs_n};
            mosi_sync   <= {mosi_sync[1:0], mosi};
            sync_primed <= {sync_primed[0], 1'b1};
        end
    end

    // State register and arming flag. The block arms once a genuine synchronised cs_n high is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            armed   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (sync_primed[1] && cs_sync[1])
                armed <= 1'b1;
        end
    end

    // Next-state logic and frame start/close strobes.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        close_ok  = 1'b0;
        close_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    if (armed) begin
                        state_d = ACTIVE;
                        start   = 1'b1;
                    end else begin
                        state_d = ABORT;
                    end
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    if (bit_cnt == CNT_W'(FRAME_BITS))
                        close_ok = 1'b1;
                    else
                        close_err = 1'b1;
                end
            end
            ABORT: begin
                if (cs_rise)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift registers, bit counter and TX holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_hold     <= '0;
            tx_pending  <= 1'b0;
            close_ok_q  <= 1'b0;
            close_err_q <= 1'b0;
        end else begin
            close_ok_q  <= close_ok;
            close_err_q <= close_err;
            if (start) begin
                bit_cnt    <= '0;
                tx_shift   <= tx_pending ? tx_hold : '1;
                tx_pending <= 1'b0;
            end else if (state_q == ACTIVE && !cs_rise) begin
                if (sclk_rise) begin
                    rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
                    if (bit_cnt != CNT_W'(FRAME_BITS + 1))
                        bit_cnt <= bit_cnt + 1'b1;
                end
                if (sclk_fall)
                    tx_shift <= {tx_shift[TX_BITS-2:0], 1'b0};
            end
            // A load is only accepted while nothing is pending. The frame starting in the
            // same cycle has already taken the old content, so the new word waits.
            if (tx_load && tx_ready) begin
                tx_hold    <= tx_data;
                tx_pending <= 1'b1;
            end
        end
    end

    // Registered outputs, one cycle behind the state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            miso_q    <= 1'b0;
        end else begin
            rx_valid  <= close_ok_q;
            frame_err <= close_err_q;
            if (close_ok_q)
                rx_data <= rx_shift;
            miso_q <= (state_q == ACTIVE) ? tx_shift[TX_BITS-1] : 1'b0;
        end
    end

`ifdef SPI_SLAVE_RESP_MISO_TRISTATE_EN
    logic miso_oe;

    // Output enable follows the frame with the same one-cycle delay as miso_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            miso_oe <= 1'b0;
        else
            miso_oe <= (state_q == ACTIVE);
    end

    assign miso = miso_oe ? miso_q : 1'bz;
`else
    assign miso = miso_q;
`endif

endmodule

// File: tb/tb_spi_slave_resp.sv
// tb_spi_slave_resp: directed and randomised frames for spi_slave_resp.
// The reference model tracks the pending TX word and the last good RX frame.
// The SPI master is driven at clk negedges, with 5-clk sclk phases.
module tb_spi_slave_resp;

    localparam int FB = 32;
    localparam int TB = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sclk = 1'b0;
    logic          cs_n = 1'b1;
    logic          mosi = 1'b0;
    logic          tx_load = 1'b0;
    logic [TB-1:0] tx_data = '0;
    wire           miso;
    logic [FB-1:0] rx_data;
    logic          rx_valid, frame_err, tx_ready;

    spi_slave_resp #(.FRAME_BITS(FB), .TX_BITS(TB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;

    // Reference model state
    logic        m_pending = 1'b0;
    logic [15:0] m_hold = '0;
    logic [31:0] m_rx = '0;
    logic        exp_idle;

    always @(negedge clk) if (rx_valid || frame_err) pulse_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] d);
        tx_data = d;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        if (!m_pending) begin
            m_hold    = d;
            m_pending = 1'b1;
        end
        check("tx_ready_after_load", 64'(tx_ready), 64'(!m_pending));
    endtask

    // One frame of nbits sclk cycles. data[nbits-1:0] is sent MSB first.
    task automatic send_frame(input string tag, input logic [63:0] data, input int nbits);
        logic [15:0] w;
        logic [63:0] obs_m, exp_m;
        logic        ok, b;
        check({tag, "_ready_pre"}, 64'(tx_ready), 64'(!m_pending));
        w = m_pending ? m_hold : 16'hFFFF;
        m_pending = 1'b0;
        cs_n = 1'b0;
        mosi = data[nbits-1];
        repeat (4) @(negedge clk);
        check({tag, "_miso_msb_lat"}, 64'(miso), 64'(w[15]));
        repeat (2) @(negedge clk);
        check({tag, "_ready_at_start"}, 64'(tx_ready), 64'(1'b1));
        obs_m = '0;
        exp_m = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i < 16) b = w[15-i];
            else        b = 1'b0;
            obs_m = {obs_m[62:0], miso};
            exp_m = {exp_m[62:0], b};
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
            if (i + 1 < nbits) mosi = data[nbits-2-i];
            repeat (5) @(negedge clk);
        end
        check({tag, "_miso_bits"}, obs_m, exp_m);
        cs_n = 1'b1;
        mosi = 1'b0;
        ok = (nbits == 32);
        if (ok) m_rx = data[31:0];
        repeat (3) @(negedge clk);
        check({tag, "_pulse_early"}, 64'({rx_valid, frame_err}), 64'(2'b00));
        @(negedge clk);
        check({tag, "_pulse"}, 64'({rx_valid, frame_err}), 64'({ok, !ok}));
        @(negedge clk);
        check({tag, "_pulse_width"}, 64'({rx_valid, frame_err}), 64'(2'b00));
        check({tag, "_rx_data"}, 64'(rx_data), 64'(m_rx));
        check({tag, "_miso_idle"}, 64'(miso), 64'(exp_idle));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int p0, nb;
        logic [63:0] d;
`ifdef SPI_SLAVE_RESP_MISO_TRISTATE_EN
        exp_idle = 1'bz;
`else
        exp_idle = 1'b0;
`endif
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rx_data", 64'(rx_data), 64'(0));
        check("rst_pulses", 64'({rx_valid, frame_err}), 64'(0));
        check("rst_tx_ready", 64'(tx_ready), 64'(1));
        check("rst_miso", 64'(miso), 64'(exp_idle));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic frame with a loaded word
        do_load(16'hA5C3);
        send_frame("basic", 64'h8001_00FF, 32);

        // No pending load: all ones on miso
        send_frame("no_load", 64'h1234_5678, 32);

        // Short and long frames
        send_frame("short31", 64'h7FFF_FFFF, 31);
        send_frame("long33", 64'h1_0000_0001, 33);

        // Second load while pending is ignored
        do_load(16'h1111);
        do_load(16'h2222);
        send_frame("double_load", 64'hCAFE_F00D, 32);

        // Reset ten clocks into a frame, released with cs_n still low
        do_load(16'h3333);
        cs_n = 1'b0;
        repeat (10) @(negedge clk);
        m_pending = 1'b0;
        do_load(16'h4444);
        check("midframe_ready", 64'(tx_ready), 64'(0));
        rst_n = 1'b0;
        @(negedge clk);
        m_pending = 1'b0;
        m_rx = '0;
        check("midrst_rx_data", 64'(rx_data), 64'(0));
        check("midrst_pulses", 64'({rx_valid, frame_err}), 64'(0));
        check("midrst_tx_ready", 64'(tx_ready), 64'(1));
        check("midrst_miso", 64'(miso), 64'(exp_idle));
        rst_n = 1'b1;
        p0 = pulse_cnt;
        for (int i = 0; i < 22; i++) begin
            mosi = 1'($urandom);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
            repeat (5) @(negedge clk);
        end
        check("dropped_miso", 64'(miso), 64'(exp_idle));
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("dropped_no_pulse", 64'(pulse_cnt - p0), 64'(0));
        check("dropped_rx_data", 64'(rx_data), 64'(m_rx));
        send_frame("after_reset", {$urandom, $urandom}, 32);

        // Randomised frames
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) do_load(16'($urandom));
            if ($urandom_range(0, 3) == 0) do_load(16'($urandom));
            case ($urandom_range(0, 5))
                0:       nb = 31;
                1:       nb = 33;
                default: nb = 32;
            endcase
            d = {$urandom, $urandom};
            send_frame("rand", d, nb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
